pc_run_controller: RTL and testbench

- Sequences the 16-bit MIPS program counter and the 4-phase micro-cycle: run, single-step, back-step, stop, clear.
- Sits between the front-panel request decoder and the PC register.
- Consumes the rate-divider tick and drives the PC advance, back-step and clear strobes.
- Provides breakpoint halting and honours the CPU halt signal.

---
 rtl/mips16_ctrl_pkg.sv | 21 ++
 rtl/pc_run_controller_phase_sequencer.sv | 32 +++
 rtl/pc_run_controller.sv | 150 +++++++++++++++
 tb/tb_pc_run_controller.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips16_ctrl_pkg.sv
// Shared definitions for the MIPS16 run controller: state encoding, phase names, default widths.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mips16_ctrl_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int NPHASE_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [1:0] PH_FETCH  = 2'd0;
  localparam logic [1:0] PH_DECODE = 2'd1;
  localparam logic [1:0] PH_EXEC   = 2'd2;
  localparam logic [1:0] PH_WBACK  = 2'd3;

endpackage

// File: rtl/pc_run_controller_phase_sequencer.sv
// Tick-qualified modulo-NPHASE micro-phase counter with synchronous clear and wrap indication.
// Latency: phase updates one cycle after adv; wrap is combinational from adv and current phase.
// Backpressure: none; adv low simply holds the phase.
module phase_sequencer #(
  parameter int NPHASE = 4,
  parameter int PH_W   = $clog2(NPHASE)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            adv,
  output logic [PH_W-1:0] phase,
  output logic            wrap
);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(NPHASE - 1);

  // Wrap marks the advancing tick that retires the last phase of an instruction.
  assign wrap = adv && (phase == PH_LAST);

  // Phase counter: clear wins, otherwise step on adv and wrap at the last phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (adv) begin
      phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
    end
  end

endmodule

// File: rtl/pc_run_controller.sv
// Run/step/back-step/stop/clear sequencer for the PC and the 4-phase micro-cycle, with breakpoint halt.
// Latency: every output is registered; strobes appear the cycle after the qualifying tick or request.
// Backpressure: none; without tick the controller holds its phase indefinitely.
module pc_run_controller
  import mips16_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NPHASE = NPHASE_DEF,
  localparam int PH_W  = $clog2(NPHASE)
) (
  input  logic              clk,
  input  logic              Clear_n,
  input  logic              tick,
  input  logic              run_req,
  input  logic              step_req,
  input  logic              back_req,
  input  logic              stop_req,
  input  logic              clr_req,
  input  logic              cpu_halt,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic [PH_W-1:0]   phase,
  output logic              pc_adv,
  output logic              pc_back,
  output logic              pc_clear,
  output logic              running,
  output logic              halted,
  output logic              bp_hit
);

  state_t state;
  logic   stop_pend;
  logic   skip_bp;
  logic   active;
  logic   bp_stop;
  logic   seq_adv;
  logic   seq_clr;
  logic   seq_wrap;

  // Qualify ticks: breakpoint check at the phase-0 tick of a run, otherwise advance the phase.
  always_comb begin
    active  = (state == S_RUN) || (state == S_STEP);
    bp_stop = 1'b0;
    seq_adv = 1'b0;
    seq_clr = clr_req;
    if (!clr_req && active && tick) begin
      if ((state == S_RUN) && (phase == '0) && bp_en && (pc_addr == bp_addr) && !skip_bp) begin
        bp_stop = 1'b1;
      end else begin
        seq_adv = 1'b1;
      end
    end
  end

  phase_sequencer #(
    .NPHASE (NPHASE),
    .PH_W   (PH_W)
  ) u_phase_sequencer (
    .clk   (clk),
    .rst_n (Clear_n),
    .clr   (seq_clr),
    .adv   (seq_adv),
    .phase (phase),
    .wrap  (seq_wrap)
  );

  // Control FSM with registered strobes and status; clr_req overrides every state.
  always_ff @(posedge clk or negedge Clear_n) begin
    if (!Clear_n) begin
      state     <= S_IDLE;
      stop_pend <= 1'b0;
      skip_bp   <= 1'b0;
      pc_adv    <= 1'b0;
      pc_back   <= 1'b0;
      pc_clear  <= 1'b0;
      running   <= 1'b0;
      halted    <= 1'b0;
      bp_hit    <= 1'b0;
    end else begin
      pc_adv   <= 1'b0;
      pc_back  <= 1'b0;
      pc_clear <= 1'b0;
      if (clr_req) begin
        state     <= S_IDLE;
        stop_pend <= 1'b0;
        skip_bp   <= 1'b0;
        pc_clear  <= 1'b1;
        running   <= 1'b0;
        halted    <= 1'b0;
        bp_hit    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            // A stop request outranks run/step and has nothing to stop while idle.
            if (stop_req) begin
              state <= S_IDLE;
            end else if (run_req) begin
              state   <= S_RUN;
              skip_bp <= 1'b1;
              bp_hit  <= 1'b0;
              running <= 1'b1;
            end else if (step_req) begin
              state   <= S_STEP;
              bp_hit  <= 1'b0;
              running <= 1'b1;
            end else if (back_req && (pc_addr != '0)) begin
              pc_back <= 1'b1;
            end
          end
          S_RUN, S_STEP: begin
            if (stop_req) begin
              stop_pend <= 1'b1;
            end
            if (bp_stop) begin
              state     <= S_IDLE;
              bp_hit    <= 1'b1;
              running   <= 1'b0;
              stop_pend <= 1'b0;
            end else if (seq_adv) begin
              if (phase == '0) begin
                skip_bp <= 1'b0;
              end
              if (seq_wrap) begin
                if (cpu_halt) begin
                  state     <= S_HALT;
                  halted    <= 1'b1;
                  running   <= 1'b0;
                  stop_pend <= 1'b0;
                end else begin
                  pc_adv <= 1'b1;
                  // Instruction boundary: a stop seen in this same cycle also takes effect.
                  if ((state == S_STEP) || stop_pend || stop_req) begin
                    state     <= S_IDLE;
                    running   <= 1'b0;
                    stop_pend <= 1'b0;
                  end
                end
              end
            end
          end
          default: begin
            state <= S_HALT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_run_controller.sv
// Directed check of pc_run_controller: vector table plus multi-cycle sequences.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_pc_run_controller;

  logic       clk;
  logic       Clear_n;
  logic       tick, run_req, step_req, back_req, stop_req, clr_req, cpu_halt;
  logic [9:0] pc_addr;
  logic       bp_en;
  logic [9:0] bp_addr;
  logic [1:0] phase;
  logic       pc_adv, pc_back, pc_clear, running, halted, bp_hit;

  int n_chk  = 0;
  int n_fail = 0;
  int adv_cnt = 0;

  pc_run_controller #(.ADDR_W(10), .NPHASE(4)) dut (
    .clk      (clk),
    .Clear_n  (Clear_n),
    .tick     (tick),
    .run_req  (run_req),
    .step_req (step_req),
    .back_req (back_req),
    .stop_req (stop_req),
    .clr_req  (clr_req),
    .cpu_halt (cpu_halt),
    .pc_addr  (pc_addr),
    .bp_en    (bp_en),
    .bp_addr  (bp_addr),
    .phase    (phase),
    .pc_adv   (pc_adv),
    .pc_back  (pc_back),
    .pc_clear (pc_clear),
    .running  (running),
    .halted   (halted),
    .bp_hit   (bp_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in  = {tick, run, step, back, stop, clr, halt}
  // out = {pc_adv, pc_back, pc_clear, running, halted, bp_hit}
  typedef struct {
    logic [6:0] in;
    logic [9:0] pc;
    logic [1:0] ph;
    logic [5:0] out;
  } vec_t;

  vec_t tv[$];

  function automatic void add(input logic [6:0] in, input logic [9:0] pc,
                              input logic [1:0] ph, input logic [5:0] out);
    vec_t v;
    v.in = in; v.pc = pc; v.ph = ph; v.out = out;
    tv.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] outs();
    return {pc_adv, pc_back, pc_clear, running, halted, bp_hit};
  endfunction

  // One clock; afterwards the bench PC follows the DUT strobes like the real PC register.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (pc_adv) begin
      adv_cnt++;
      pc_addr = pc_addr + 10'd1;
    end
    if (pc_back) pc_addr = pc_addr - 10'd1;
    if (pc_clear) pc_addr = '0;
  endtask

  task automatic clr_inputs();
    {tick, run_req, step_req, back_req, stop_req, clr_req, cpu_halt} = '0;
  endtask

  // Tick with slack so the bench PC settles before the next tick.
  task automatic tk();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic pulse_run();  run_req = 1'b1;  cyc(); run_req = 1'b0;  endtask
  task automatic pulse_step(); step_req = 1'b1; cyc(); step_req = 1'b0; endtask
  task automatic pulse_stop(); stop_req = 1'b1; cyc(); stop_req = 1'b0; endtask
  task automatic pulse_clr();  clr_req = 1'b1;  cyc(); clr_req = 1'b0;  endtask

  initial begin
    Clear_n = 1'b0;
    clr_inputs();
    pc_addr = '0;
    bp_en   = 1'b0;
    bp_addr = '0;

    // Single step, tick gating, back-step, halt and clear.
    add(7'b0000000, 10'd0, 2'd0, 6'b000000);
    add(7'b0010000, 10'd0, 2'd0, 6'b000100);
    add(7'b1000000, 10'd0, 2'd1, 6'b000100);
    add(7'b0000000, 10'd0, 2'd1, 6'b000100);
    add(7'b1000000, 10'd0, 2'd2, 6'b000100);
    add(7'b1000000, 10'd0, 2'd3, 6'b000100);
    add(7'b1000000, 10'd0, 2'd0, 6'b100000);
    add(7'b0000000, 10'd0, 2'd0, 6'b000000);
    add(7'b1000000, 10'd0, 2'd0, 6'b000000);
    add(7'b0001000, 10'd3, 2'd0, 6'b010000);
    add(7'b0000000, 10'd3, 2'd0, 6'b000000);
    add(7'b0001000, 10'd0, 2'd0, 6'b000000);
    add(7'b0010000, 10'd0, 2'd0, 6'b000100);
    add(7'b0001000, 10'd3, 2'd0, 6'b000100);
    add(7'b1000000, 10'd3, 2'd1, 6'b000100);
    add(7'b1000000, 10'd3, 2'd2, 6'b000100);
    add(7'b1000000, 10'd3, 2'd3, 6'b000100);
    add(7'b1000001, 10'd3, 2'd0, 6'b000010);
    add(7'b0100000, 10'd3, 2'd0, 6'b000010);
    add(7'b0010000, 10'd3, 2'd0, 6'b000010);
    add(7'b0001000, 10'd3, 2'd0, 6'b000010);
    add(7'b1000000, 10'd3, 2'd0, 6'b000010);
    add(7'b0000010, 10'd3, 2'd0, 6'b001000);
    add(7'b0000000, 10'd3, 2'd0, 6'b000000);

    // Reset state while Clear_n is held low.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_phase", 32'(phase), 32'd0);
    chk("reset_outs", 32'(outs()), 32'd0);
    @(negedge clk);
    Clear_n = 1'b1;
    cyc();

    for (int i = 0; i < tv.size(); i++) begin
      {tick, run_req, step_req, back_req, stop_req, clr_req, cpu_halt} = tv[i].in;
      pc_addr = tv[i].pc;
      cyc();
      chk($sformatf("vec%0d_phase", i), 32'(phase), 32'(tv[i].ph));
      chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(tv[i].out));
    end
    clr_inputs();

    // Run into a breakpoint at 5, resume, then stop mid-instruction.
    pulse_clr();
    pc_addr = '0;
    adv_cnt = 0;
    bp_en   = 1'b1;
    bp_addr = 10'd5;
    pulse_run();
    chk("run_running", 32'(running), 32'd1);
    for (int i = 0; i < 20; i++) tk();
    chk("bp_adv_count", 32'(adv_cnt), 32'd5);
    chk("bp_pc", 32'(pc_addr), 32'd5);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("bp_stop_outs", 32'(outs()), 32'b000001);
    chk("bp_stop_phase", 32'(phase), 32'd0);
    cyc();
    tk();
    chk("bp_idle_hold", 32'(phase), 32'd0);
    chk("bp_no_adv", 32'(adv_cnt), 32'd5);
    pulse_run();
    chk("resume_bp_clr", 32'(outs()), 32'b000100);
    for (int i = 0; i < 4; i++) tk();
    chk("resume_adv", 32'(adv_cnt), 32'd6);
    chk("resume_running", 32'(running), 32'd1);
    tk();
    pulse_stop();
    chk("stop_inflight", 32'(running), 32'd1);
    tk();
    tk();
    chk("stop_phase3", 32'(phase), 32'd3);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("stop_adv_pulse", 32'(outs()), 32'b100000);
    cyc();
    chk("stop_adv_count", 32'(adv_cnt), 32'd7);
    tk();
    chk("stop_no_phase", 32'(phase), 32'd0);
    chk("stop_idle_adv", 32'(adv_cnt), 32'd7);
    bp_en = 1'b0;

    // Asynchronous reset in phase 2, applied between clock edges.
    pulse_step();
    tk();
    tk();
    chk("pre_rst_phase", 32'(phase), 32'd2);
    #3;
    Clear_n = 1'b0;
    #1;
    chk("async_rst_phase", 32'(phase), 32'd0);
    chk("async_rst_outs", 32'(outs()), 32'd0);
    #2;
    Clear_n = 1'b1;
    cyc();
    tk();
    chk("post_rst_idle", 32'(phase), 32'd0);

    // Clear and run in the same cycle: clear wins.
    pulse_run();
    tk();
    chk("pre_clr_phase", 32'(phase), 32'd1);
    clr_req = 1'b1;
    run_req = 1'b1;
    cyc();
    clr_inputs();
    chk("clr_run_outs", 32'(outs()), 32'b001000);
    chk("clr_run_phase", 32'(phase), 32'd0);
    tk();
    chk("clr_run_idle", 32'(phase), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
